// File: rtl/dctq_pkg.sv
// Shared constants, zigzag table and read-FSM state type for the DCTQ zigzag/RLE stage.
// DC_DIFF_EN widens levels by one bit for DC differential coding.
package dctq_pkg;

    localparam int RUN_W = 4;
    localparam logic [RUN_W-1:0] ZRL_RUN = RUN_W'(15);

`ifdef DC_DIFF_EN
    localparam int DC_DIFF_W = 1;
`else
    localparam int DC_DIFF_W = 0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH_ZRL,
        ST_EOB
    } rd_state_t;

    // zigzag scan index -> row-major address
    localparam logic [5:0] ZZ_TABLE [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/dctq_zigzag_rom.sv
// Combinational zigzag ROM: scan index -> row-major coefficient address.
module dctq_zigzag_rom
    import dctq_pkg::*;
(
    input  logic [5:0] idx,
    output logic [5:0] addr
);

    assign addr = ZZ_TABLE[idx];

endmodule

// File: rtl/dctq_zigzag_rle.sv
// Ping-pong block buffer, zigzag rescan and (run, level) tokenizer after the DCTQ core.
// Optional macro DC_DIFF_EN: DC level emitted as difference to previous accepted DC.
module dctq_zigzag_rle
    import dctq_pkg::*;
#(
    parameter  int COEF_W = 9,
    localparam int LVL_W  = COEF_W + DC_DIFF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COEF_W-1:0] dctq1,
    input  logic              dctq_valid,
    input  logic [5:0]        addr,
    output logic              hold,
    output logic              ovf,
    output logic              rle_valid,
    input  logic              rle_ready,
    output logic [RUN_W-1:0]  rle_run,
    output logic [LVL_W-1:0]  rle_level,
    output logic              rle_eob
);

    logic signed [COEF_W-1:0] mem [2][64];
    logic [1:0]               full, full_next;
    logic                     wbank, rbank;
    rd_state_t                state;
    logic [5:0]               idx, zz_addr;
    logic [RUN_W-1:0]         run;
    logic [1:0]               zrl;
    logic signed [COEF_W-1:0] coef;
    logic signed [LVL_W-1:0]  coef_ext, dc_level;
    logic                     advance, wr_en, fill, rel_bank;

    dctq_zigzag_rom u_rom (
        .idx  (idx),
        .addr (zz_addr)
    );

    assign coef     = mem[rbank][zz_addr];
    assign coef_ext = LVL_W'(coef);
    assign advance  = !rle_valid || rle_ready;
    assign wr_en    = dctq_valid && !hold;
    assign fill     = wr_en && (addr == 6'd63);
    assign rel_bank = (state == ST_EOB) && rle_valid && rle_eob && rle_ready;

`ifdef DC_DIFF_EN
    logic signed [LVL_W-1:0] dc_pred;
    logic                    out_dc;

    assign dc_level = coef_ext - dc_pred;

    // rle_level holds DC - dc_pred, so adding it back recovers the raw DC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dc_pred <= '0;
            out_dc  <= 1'b0;
        end else begin
            if (advance)
                out_dc <= (state == ST_SCAN) && (idx == '0);
            if (rle_valid && rle_ready && out_dc)
                dc_pred <= dc_pred + rle_level;
        end
    end
`else
    assign dc_level = coef_ext;
`endif

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wbank][addr] <= dctq1;
    end

    // fill and release always hit opposite banks, so both apply in the same cycle
    always_comb begin
        full_next = full;
        if (fill)
            full_next[wbank] = 1'b1;
        if (rel_bank)
            full_next[rbank] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full  <= '0;
            hold  <= 1'b0;
            ovf   <= 1'b0;
            wbank <= 1'b0;
        end else begin
            full <= full_next;
            hold <= &full_next;
            ovf  <= ovf || (dctq_valid && hold);
            if (fill)
                wbank <= !wbank;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rbank     <= 1'b0;
            idx       <= '0;
            run       <= '0;
            zrl       <= '0;
            rle_valid <= 1'b0;
            rle_run   <= '0;
            rle_level <= '0;
            rle_eob   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (full[rbank]) begin
                        state <= ST_SCAN;
                        idx   <= '0;
                        run   <= '0;
                        zrl   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (advance) begin
                        if (idx == '0) begin
                            rle_valid <= 1'b1;
                            rle_eob   <= 1'b0;
                            rle_run   <= '0;
                            rle_level <= dc_level;
                            idx       <= 6'd1;
                        end else if (coef == '0) begin
                            rle_valid <= 1'b0;
                            if (idx == 6'd63) begin
                                state <= ST_EOB;
                            end else begin
                                idx <= idx + 6'd1;
                                if (run == ZRL_RUN) begin
                                    zrl <= zrl + 2'd1;
                                    run <= '0;
                                end else begin
                                    run <= run + 1'b1;
                                end
                            end
                        end else if (zrl != '0) begin
                            rle_valid <= 1'b0;
                            state     <= ST_FLUSH_ZRL;
                        end else begin
                            rle_valid <= 1'b1;
                            rle_eob   <= 1'b0;
                            rle_run   <= run;
                            rle_level <= coef_ext;
                            run       <= '0;
                            if (idx == 6'd63)
                                state <= ST_EOB;
                            else
                                idx <= idx + 6'd1;
                        end
                    end
                end
                ST_FLUSH_ZRL: begin
                    if (advance) begin
                        rle_valid <= 1'b1;
                        rle_eob   <= 1'b0;
                        rle_run   <= ZRL_RUN;
                        rle_level <= '0;
                        zrl       <= zrl - 2'd1;
                        if (zrl == 2'd1)
                            state <= ST_SCAN;
                    end
                end
                ST_EOB: begin
                    if (!rle_eob) begin
                        if (advance) begin
                            rle_valid <= 1'b1;
                            rle_eob   <= 1'b1;
                            rle_run   <= '0;
                            rle_level <= '0;
                        end
                    end else if (rle_ready) begin
                        rle_valid <= 1'b0;
                        rle_eob   <= 1'b0;
                        rbank     <= !rbank;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dctq_zigzag_rle.sv
// Self-checking bench for dctq_zigzag_rle: table-driven blocks plus backpressure, overflow and reset sequences.
// Honours DC_DIFF_EN when defined for the DC-differential expectations.
module tb_dctq_zigzag_rle;

`ifdef DC_DIFF_EN
    localparam int LVL_W = 10;
`else
    localparam int LVL_W = 9;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic [8:0]              dctq1;
    logic                    dctq_valid;
    logic [5:0]              addr;
    logic                    hold, ovf, rle_valid, rle_ready, rle_eob;
    logic [3:0]              rle_run;
    logic signed [LVL_W-1:0] rle_level;

    dctq_zigzag_rle dut (
        .clk        (clk),
        .reset      (reset),
        .dctq1      (dctq1),
        .dctq_valid (dctq_valid),
        .addr       (addr),
        .hold       (hold),
        .ovf        (ovf),
        .rle_valid  (rle_valid),
        .rle_ready  (rle_ready),
        .rle_run    (rle_run),
        .rle_level  (rle_level),
        .rle_eob    (rle_eob)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    a [3];
        int    v [3];
        int    n;
        int    erun [6];
        int    elvl [6];
    } vec_t;

    vec_t vecs [8];
    int   total = 0;
    int   bad   = 0;
    int   blk [64];
    int   pred;
    int   exp_n;
    int   exp_run [6];
    int   exp_lvl [6];
    bit   stalled;
    int   saved;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_blk(input int i);
        for (int k = 0; k < 64; k++) blk[k] = 0;
        for (int k = 0; k < 3; k++)
            if (vecs[i].a[k] >= 0) blk[vecs[i].a[k]] = vecs[i].v[k];
    endtask

    task automatic build_exp(input int i);
        exp_n = vecs[i].n;
        for (int k = 0; k < 6; k++) begin
            exp_run[k] = vecs[i].erun[k];
            exp_lvl[k] = vecs[i].elvl[k];
        end
`ifdef DC_DIFF_EN
        exp_lvl[0] = vecs[i].elvl[0] - pred;
        pred       = vecs[i].elvl[0];
`endif
    endtask

    task automatic write_blk();
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            dctq_valid = 1'b1;
            addr       = 6'(a);
            dctq1      = 9'(blk[a]);
        end
        @(negedge clk);
        dctq_valid = 1'b0;
    endtask

    function automatic int snap();
        return int'({rle_valid, rle_eob, rle_run, 9'(rle_level)});
    endfunction

    // consumes exp_n tokens then EOB; ready is chosen first so valid&ready predicts the next edge
    task automatic collect(input string name, input bit rnd);
        stalled = 1'b0;
        for (int k = 0; k <= exp_n; k++) begin
            bit got = 1'b0;
            int cyc = 0;
            while (!got) begin
                @(negedge clk);
                if (stalled) check({name, "_stable"}, snap(), saved);
                rle_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (rle_valid && rle_ready) begin
                    got = 1'b1;
                    if (k < exp_n) begin
                        check($sformatf("%s_run%0d", name, k), int'(rle_run), exp_run[k]);
                        check($sformatf("%s_lvl%0d", name, k), int'(rle_level), exp_lvl[k]);
                        check($sformatf("%s_eob%0d", name, k), int'(rle_eob), 0);
                    end else begin
                        check({name, "_eob"}, int'({rle_eob, rle_run, 9'(rle_level)}), 1 << 13);
                    end
                end
                stalled = rle_valid && !rle_ready;
                saved   = snap();
                cyc++;
                if (!got && cyc >= 2000) begin
                    check({name, "_timeout"}, 0, 1);
                    return;
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; dctq_valid = 1'b0; addr = '0; dctq1 = '0; rle_ready = 1'b1; pred = 0;
        vecs[0] = '{"dc_only",   '{0, -1, -1}, '{5, 0, 0},    1, '{0, 0, 0, 0, 0, 0},     '{5, 0, 0, 0, 0, 0}};
        vecs[1] = '{"ac_pair",   '{0, 1, 8},   '{2, -3, 7},   3, '{0, 0, 0, 0, 0, 0},     '{2, -3, 7, 0, 0, 0}};
        vecs[2] = '{"zrl_x3",    '{0, 63, -1}, '{0, 1, 0},    5, '{0, 15, 15, 15, 14, 0}, '{0, 0, 0, 0, 1, 0}};
        vecs[3] = '{"extremes",  '{0, 63, -1}, '{-256, 255, 0}, 5, '{0, 15, 15, 15, 14, 0}, '{-256, 0, 0, 0, 255, 0}};
        vecs[4] = '{"run7",      '{0, 17, -1}, '{1, -1, 0},   2, '{0, 7, 0, 0, 0, 0},     '{1, -1, 0, 0, 0, 0}};
        vecs[5] = '{"zrl_exact", '{0, 19, -1}, '{3, -9, 0},   3, '{0, 15, 0, 0, 0, 0},    '{3, 0, -9, 0, 0, 0}};
        vecs[6] = '{"run15",     '{0, 12, -1}, '{-1, 4, 0},   2, '{0, 15, 0, 0, 0, 0},    '{-1, 4, 0, 0, 0, 0}};
        vecs[7] = '{"all_zero",  '{0, -1, -1}, '{0, 0, 0},    1, '{0, 0, 0, 0, 0, 0},     '{0, 0, 0, 0, 0, 0}};

        repeat (3) @(negedge clk);
        check("reset_outputs", int'({hold, ovf, rle_valid, rle_eob, rle_run, 9'(rle_level)}), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rle_ready = (i != 0);
            load_blk(i);
            build_exp(i);
            write_blk();
            if (i == 0) begin
                check("lat_T0", int'(rle_valid), 0);
                @(negedge clk);
                check("lat_T1", int'(rle_valid), 0);
                @(negedge clk);
                check("lat_T2", int'(rle_valid), 1);
            end
            collect(vecs[i].name, 1'b0);
            @(negedge clk);
            check({vecs[i].name, "_idle"}, int'(rle_valid), 0);
        end

        load_blk(1);
        build_exp(1);
        write_blk();
        collect("rand_ready", 1'b1);
        rle_ready = 1'b1;
        @(negedge clk);
        check("rand_idle", int'(rle_valid), 0);

        rle_ready = 1'b0;
        load_blk(1);
        write_blk();
        check("bp_hold_one", int'(hold), 0);
        load_blk(2);
        write_blk();
        check("bp_hold_two", int'(hold), 1);
        check("bp_ovf_pre", int'(ovf), 0);
        for (int k = 0; k < 64; k++) blk[k] = 1;
        write_blk();
        check("bp_ovf_post", int'(ovf), 1);
        check("bp_hold_still", int'(hold), 1);
        build_exp(1);
        collect("bp_blk1", 1'b0);
        check("bp_hold_at_eob", int'(hold), 1);
        @(negedge clk);
        check("bp_hold_drop", int'(hold), 0);
        build_exp(2);
        collect("bp_blk2", 1'b0);
        @(negedge clk);
        check("bp_idle", int'(rle_valid), 0);
        check("bp_ovf_sticky", int'(ovf), 1);

        rle_ready = 1'b0;
        load_blk(3);
        write_blk();
        repeat (3) @(negedge clk);
        check("rst_pre_valid", int'(rle_valid), 1);
        #2 reset = 1'b1;
        #1 check("rst_outputs", int'({hold, ovf, rle_valid, rle_eob, rle_run, 9'(rle_level)}), 0);
        @(negedge clk);
        reset     = 1'b0;
        rle_ready = 1'b1;
        pred      = 0;
        begin
            int seen = 0;
            repeat (8) begin
                @(negedge clk);
                seen += int'(rle_valid);
            end
            check("rst_no_tokens", seen, 0);
        end
`ifdef DC_DIFF_EN
        for (int k = 0; k < 64; k++) blk[k] = 0;
        blk[0] = 10;
        exp_n = 1; exp_run[0] = 0; exp_lvl[0] = 10;
        write_blk();
        collect("dcd_first", 1'b0);
        blk[0] = 4;
        exp_lvl[0] = -6;
        write_blk();
        collect("dcd_second", 1'b0);
        pred = 4;
`endif
        load_blk(1);
        build_exp(1);
        write_blk();
        collect("post_reset", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
